// File: rtl/alu_pkg.sv
// Shared definitions for the sequential EX-stage ALU: op-codes, FSM states
// and the iteration-counter width helper.
// Optional divider support is selected by the ALU_DIV_EN macro (see seq_alu).
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Bits needed to count 0 .. width-1 iterations.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/done request bus between the control FSM (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataout;
    logic [WIDTH-1:0] dataout_hi;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, alu_op, data1, data2,
        input  busy, done, dataout, dataout_hi, zero, overflow, illegal
    );

    modport slave (
        input  start, alu_op, data1, data2,
        output busy, done, dataout, dataout_hi, zero, overflow, illegal
    );

endinterface

// File: rtl/seq_alu_iter.sv
// Iterative datapath for seq_alu: radix-2 shift-add multiplier and, when
// ALU_DIV_EN is defined, a restoring divider sharing the same hi/lo shift
// register, adder and iteration counter.
// After i_load it runs WIDTH steps, then raises o_fin until the next load.
// MUL:  {o_hi,o_lo} = i_a * i_b.   DIV: o_lo = i_a / i_b, o_hi = i_a % i_b
// (divide by zero: quotient all-ones, remainder = i_a).
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
`ifdef ALU_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_count;
    logic             r_run;
    logic             r_fin;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;

`ifdef ALU_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_op_a;
    logic [WIDTH+1:0] w_op_b;
    logic [WIDTH+1:0] w_sum;

    // Partial remainder shifted left with the next dividend bit.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};

    // One shared adder: MUL adds the gated multiplicand, DIV subtracts the divisor.
    always_comb begin
        w_op_a = r_div ? {1'b0, w_shift} : {2'b00, r_hi};
        w_op_b = r_div ? ~{2'b00, r_m} : (r_lo[0] ? {2'b00, r_m} : '0);
    end

    assign w_sum = w_op_a + w_op_b + {{(WIDTH + 1){1'b0}}, r_div};
`else
    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
`endif

    // Load operands, then one shift-add (or shift-subtract) step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are reset as well so a mid-op reset leaves no stale state.
        if (reset) begin
            r_count <= '0;
            r_run   <= 1'b0;
            r_fin   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
`ifdef ALU_DIV_EN
            r_div   <= 1'b0;
`endif
        end else if (i_load) begin
            r_count <= '0;
            r_run   <= 1'b1;
            r_fin   <= 1'b0;
            r_hi    <= '0;
`ifdef ALU_DIV_EN
            r_div   <= i_div;
            r_lo    <= i_div ? i_a : i_b;
            r_m     <= i_div ? i_b : i_a;
`else
            r_lo    <= i_b;
            r_m     <= i_a;
`endif
        end else if (r_run) begin
`ifdef ALU_DIV_EN
            if (r_div) begin
                if (!w_sum[WIDTH+1]) begin
                    r_hi <= w_sum[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
`else
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
`endif
            if (r_count == LAST) begin
                r_run <= 1'b0;
                r_fin <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_fin = r_fin;
    assign o_hi  = r_hi;
    assign o_lo  = r_lo;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle EX-stage ALU with start/busy/done handshake.
// Holds the control FSM, the single-cycle ops (AND/OR/ADD/SUB) and the
// registered result/flag outputs; MUL (and DIVU/REMU) run in seq_alu_iter.
// Define ALU_DIV_EN to enable DIVU/REMU; otherwise those codes are illegal.
// Results and flags stay stable from one done pulse to the next.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus
);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_dataout;
    logic [WIDTH-1:0] r_dataout_hi;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_load;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic             w_fin;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_accept = bus.start && (r_state == S_IDLE);
    assign w_is_mul = (bus.alu_op == OP_MUL);

`ifdef ALU_DIV_EN
    logic w_is_div;
    assign w_is_div = (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
    assign w_load   = w_accept && (w_is_mul || w_is_div);
`else
    assign w_load   = w_accept && w_is_mul;
`endif

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
`ifdef ALU_DIV_EN
        .i_div  (w_is_div),
`endif
        .i_a    (bus.data1),
        .i_b    (bus.data2),
        .o_fin  (w_fin),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    assign w_add = r_a + r_b;
    assign w_sub = r_a - r_b;

    // Single-cycle result and flags from the latched operands.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_ADD: begin
                w_res = w_add;
                w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub;
                w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register update on the same clock edge.
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dataout    <= '0;
            r_dataout_hi <= '0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= bus.alu_op;
                        r_a    <= bus.data1;
                        r_b    <= bus.data2;
                        r_busy <= 1'b1;
                        if (w_is_mul) begin
                            r_state <= S_MUL;
`ifdef ALU_DIV_EN
                        end else if (w_is_div) begin
                            r_state <= S_DIV;
`endif
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_state      <= S_DONE;
                    r_done       <= 1'b1;
                    r_dataout    <= w_res;
                    r_dataout_hi <= '0;
                    r_zero       <= (w_res == '0);
                    r_overflow   <= w_ovf;
                    r_illegal    <= w_ill;
                end
                S_MUL: begin
                    if (w_fin) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_dataout    <= w_lo;
                        r_dataout_hi <= w_hi;
                        r_zero       <= (w_lo == '0);
                        r_overflow   <= 1'b0;
                        r_illegal    <= 1'b0;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    // Iterator leaves quotient in lo and remainder in hi; REMU swaps them.
                    if (w_fin) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_overflow   <= 1'b0;
                        r_illegal    <= 1'b0;
                        if (r_op == OP_REMU) begin
                            r_dataout    <= w_hi;
                            r_dataout_hi <= w_lo;
                            r_zero       <= (w_hi == '0);
                        end else begin
                            r_dataout    <= w_lo;
                            r_dataout_hi <= w_hi;
                            r_zero       <= (w_lo == '0);
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.dataout    = r_dataout;
    assign bus.dataout_hi = r_dataout_hi;
    assign bus.zero       = r_zero;
    assign bus.overflow   = r_overflow;
    assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): the driver pushes hand-computed
// expectations, a monitor pops and compares on every done pulse.
// DIVU/REMU vectors depend on ALU_DIV_EN, matching the RTL build.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        v;
        logic        il;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_lo"},  bus.dataout, e.lo);
                    check({e.name, "_hi"},  bus.dataout_hi, e.hi);
                    check({e.name, "_zero"}, bus.zero, e.z);
                    check({e.name, "_ovf"}, bus.overflow, e.v);
                    check({e.name, "_ill"}, bus.illegal, e.il);
                    check({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    // Issue one op, optionally keep start asserted with junk while busy.
    task automatic send(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                        input logic z, input logic v, input logic il, input int lat,
                        input bit hammer);
        exp_t e;
        bit   finished;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.data1  = a;
        bus.data2  = b;
        e = '{name: nm, lo: lo, hi: hi, z: z, v: v, il: il, lat: lat, acc: cyc};
        sb.push_back(e);
        @(negedge clk);
        check({nm, "_busy"}, bus.busy, 1'b1);
        finished = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy === 1'b0) begin
                finished = 1'b1;
                break;
            end
            // Inputs change after accept; the DUT must keep its latched copy.
            bus.start  = hammer;
            bus.alu_op = OP_ADD;
            bus.data1  = $urandom;
            bus.data2  = $urandom;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!finished) check({nm, "_timeout"}, 64'd1, 64'd0);
        else check({nm, "_hold"}, bus.dataout, lo);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        cyc        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.alu_op = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_lo",   bus.dataout, 32'h0);
        check("rst_hi",   bus.dataout_hi, 32'h0);
        check("rst_zero", bus.zero, 1'b0);
        check("rst_ovf",  bus.overflow, 1'b0);
        check("rst_ill",  bus.illegal, 1'b0);
        reset = 1'b0;

        //     name        op      data1         data2         lo            hi            z     v     il    lat hammer
        send("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 2,  0);
        send("sub_zero",  OP_SUB, 32'h5,        32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2,  0);
        send("and",       OP_AND, 32'hF0F0,     32'h0FF0,     32'h00F0,     32'h0,        1'b0, 1'b0, 1'b0, 2,  0);
        send("or",        OP_OR,  32'hF0F0,     32'h0FF0,     32'hFFF0,     32'h0,        1'b0, 1'b0, 1'b0, 2,  0);
        send("sub_ovf",   OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 2,  0);
        send("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2,  1);
        send("mul_max",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 34, 1);

        // Reset in the middle of a multiply: nothing of it may survive.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = OP_MUL;
        bus.data1  = 32'h1234;
        bus.data2  = 32'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_lo",   bus.dataout, 32'h0);
        check("mid_rst_hi",   bus.dataout_hi, 32'h0);
        check("mid_rst_zero", bus.zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        send("add_after", OP_ADD, 32'h2,        32'h3,        32'h5,        32'h0,        1'b0, 1'b0, 1'b0, 2,  0);
        send("mul_small", OP_MUL, 32'h3,        32'h5,        32'hF,        32'h0,        1'b0, 1'b0, 1'b0, 34, 0);
        send("mul_carry", OP_MUL, 32'h10000,    32'h10000,    32'h0,        32'h1,        1'b1, 1'b0, 1'b0, 34, 0);
        send("illegal",   4'b0111, 32'h1234,    32'h5678,     32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 2,  0);
`ifdef ALU_DIV_EN
        send("divu",      OP_DIVU, 32'd100,     32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 34, 0);
        send("remu",      OP_REMU, 32'd100,     32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 1'b0, 34, 0);
        send("divu_zero", OP_DIVU, 32'h12345678, 32'h0,       32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b0, 34, 0);
`else
        send("divu_ill",  OP_DIVU, 32'd100,     32'd7,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 2,  0);
        send("remu_ill",  OP_REMU, 32'd100,     32'd7,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 2,  0);
`endif
        send("and_last",  OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 32'h0,        1'b0, 1'b0, 1'b0, 2,  0);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
